// File: rtl/wb_pkg.sv
// Shared Wishbone B3 constants and the burst RAM controller state type.
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLASSIC,
    ST_BURST,
    ST_ERR
  } state_e;

endpackage

// File: rtl/wb_b3_burst_ram_if.sv
// Wishbone B3 slave-side bus bundle; signal names follow the slave's view.
interface wb_b3_burst_ram_if #(
  parameter int dw = 32,
  parameter int aw = 32
);
  logic [aw-1:0]   wb_adr_i;
  logic [1:0]      wb_bte_i;
  logic [2:0]      wb_cti_i;
  logic            wb_cyc_i;
  logic            wb_stb_i;
  logic            wb_we_i;
  logic [dw/8-1:0] wb_sel_i;
  logic [dw-1:0]   wb_dat_i;
  logic            wb_ack_o;
  logic            wb_err_o;
  logic            wb_rty_o;
  logic [dw-1:0]   wb_dat_o;

  modport master (
    output wb_adr_i, wb_bte_i, wb_cti_i, wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_dat_i,
    input  wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o
  );

  modport slave (
    input  wb_adr_i, wb_bte_i, wb_cti_i, wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_dat_i,
    output wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o
  );
endinterface

// File: rtl/wb_ram_array.sv
// Single-port RAM, one byte-wide array per lane; read data is registered
// and held on write cycles so the bus read register keeps its value.
module wb_ram_array #(
  parameter int dw            = 32,
  parameter int mem_adr_width = 10
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic [dw/8-1:0]          we_i,
  input  logic [mem_adr_width-3:0] addr_i,
  input  logic [dw-1:0]            dat_i,
  output logic [dw-1:0]            dat_o
);
  localparam int DEPTH = 2 ** (mem_adr_width - 2);

  logic rd_en;
  assign rd_en = en_i & ~(|we_i);

  for (genvar gi = 0; gi < dw / 8; gi++) begin : g_lane
    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_q;

    always_ff @(posedge clk_i) begin
      if (en_i && we_i[gi]) mem_q[addr_i] <= dat_i[gi*8 +: 8];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)      rd_q <= '0;
      else if (rd_en) rd_q <= mem_q[addr_i];
    end

    assign dat_o[gi*8 +: 8] = rd_q;
  end
endmodule

// File: rtl/wb_b3_burst_ram.sv
// Wishbone B3 RAM slave: registered ack/err, classic cycles plus linear and
// wrapping incrementing bursts driven from an internal word pointer.
module wb_b3_burst_ram
  import wb_pkg::*;
#(
  parameter int          dw             = 32,
  parameter int          aw             = 32,
  parameter logic [31:0] mem_size_bytes = 32'h0000_0400,
  parameter int          mem_adr_width  = 10
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  wb_b3_burst_ram_if.slave   wb
);
  localparam int            PW       = mem_adr_width - 2;
  localparam logic [aw-1:0] MEM_SIZE = aw'(mem_size_bytes);

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d, ptr_inc;
  logic              req, in_range, inc_beat, overflow, wr_fire, ram_en;
  logic [PW-1:0]     ram_addr;
  logic [dw/8-1:0]   ram_we;

  assign req      = wb.wb_cyc_i & wb.wb_stb_i;
  assign in_range = wb.wb_adr_i < MEM_SIZE;
  assign inc_beat = (state_q == ST_BURST) & req & (wb.wb_cti_i == CTI_INC);
  assign overflow = (wb.wb_bte_i == BTE_LINEAR) & (&ptr_q);
  // Reset gates the write so an edge coinciding with reset never commits.
  assign wr_fire  = wb.wb_ack_o & req & wb.wb_we_i & ~wb_rst_i;

  always_comb begin
    ptr_inc = ptr_q + PW'(1);
    case (wb.wb_bte_i)
      BTE_WRAP4:  ptr_inc = {ptr_q[PW-1:2], ptr_q[1:0] + 2'd1};
      BTE_WRAP8:  ptr_inc = {ptr_q[PW-1:3], ptr_q[2:0] + 3'd1};
      BTE_WRAP16: ptr_inc = {ptr_q[PW-1:4], ptr_q[3:0] + 4'd1};
      default:    ptr_inc = ptr_q + PW'(1);
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (!in_range) begin
            state_d = ST_ERR;
          end else begin
            ptr_d   = wb.wb_adr_i[mem_adr_width-1:2];
            state_d = (wb.wb_cti_i == CTI_INC) ? ST_BURST : ST_CLASSIC;
          end
        end
      end
      ST_CLASSIC: state_d = ST_IDLE;
      ST_BURST: begin
        if (!req) begin
          state_d = ST_IDLE;
        end else if (wb.wb_cti_i == CTI_INC) begin
          if (overflow) state_d = ST_ERR;
          else          ptr_d   = ptr_inc;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wb.wb_ack_o = (state_q == ST_CLASSIC) || (state_q == ST_BURST);
    wb.wb_err_o = (state_q == ST_ERR);
    wb.wb_rty_o = 1'b0;
  end

  // Writes target the current beat; reads prefetch the next beat's word.
  assign ram_en   = wr_fire | ((state_q == ST_IDLE) & req & in_range) | (inc_beat & ~overflow);
  assign ram_addr = wr_fire ? ptr_q
                  : ((state_q == ST_IDLE) ? wb.wb_adr_i[mem_adr_width-1:2] : ptr_inc);
  assign ram_we   = wr_fire ? wb.wb_sel_i : '0;

  wb_ram_array #(
    .dw            (dw),
    .mem_adr_width (mem_adr_width)
  ) u_ram (
    .clk_i  (wb_clk_i),
    .rst_i  (wb_rst_i),
    .en_i   (ram_en),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .dat_i  (wb.wb_dat_i),
    .dat_o  (wb.wb_dat_o)
  );
endmodule
